// File: rtl/text_buffer_arbiter.sv
// Character RAM port arbiter: video fetch > clear sweep > external writer.
// Optional macro TEXT_BUFFER_ARBITER_SCROLL_EN adds a per-frame fetch row scroll.
module text_buffer_arbiter #(
  parameter int unsigned COLS       = 240,
  parameter int unsigned ROWS       = 135,
  parameter logic [15:0] CLEAR_CHAR = 16'h2070
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [8:0]  i_bx,
  input  logic [8:0]  i_by,
  input  logic [2:0]  i_px_lo,
  input  logic        i_offscreen,
  output logic [15:0] o_char,
  output logic [14:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [15:0] o_mem_wdata,
  input  logic [15:0] i_mem_rdata,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  input  logic [7:0]  i_wr_col,
  input  logic [7:0]  i_wr_row,
  input  logic [15:0] i_wr_data,
  output logic        o_wr_err,
`ifdef TEXT_BUFFER_ARBITER_SCROLL_EN
  input  logic [7:0]  i_scroll_row,
`endif
  input  logic        i_clear_req,
  output logic        o_clear_busy
);

  localparam int unsigned CELLS = COLS * ROWS;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e      state_q, state_d;
  logic [14:0] clr_cnt_q, clr_cnt_d;
  logic [14:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [15:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [15:0] char_q, char_d;
  logic        fetch_p1_q, fetch_p2_q;
  logic        fetch_slot_c;
  logic        wr_oor_c;
  logic        wr_xfer_c;
  logic [8:0]  fetch_row_c;

  function automatic logic [14:0] cell_addr(input logic [8:0] row, input logic [8:0] col);
    return 15'(row) * 15'(COLS) + 15'(col);
  endfunction

  assign fetch_slot_c = (i_px_lo == 3'd0) && (i_bx < 9'(COLS)) && !i_offscreen;
  assign wr_oor_c     = ({1'b0, i_wr_col} >= 9'(COLS)) || ({1'b0, i_wr_row} >= 9'(ROWS));
  assign o_wr_ready   = !fetch_slot_c && (state_q == IDLE);
  assign wr_xfer_c    = i_wr_valid && o_wr_ready;

`ifdef TEXT_BUFFER_ARBITER_SCROLL_EN
  logic [7:0] scroll_q, scroll_d;
  logic       off_q;
  logic [9:0] row_sum_c;

  // Scroll latched once per frame on the first blanking cycle, clamped into range.
  always_comb begin
    scroll_d = scroll_q;
    if (i_offscreen && !off_q) begin
      scroll_d = ({1'b0, i_scroll_row} >= 9'(ROWS)) ? 8'(ROWS - 1) : i_scroll_row;
    end
    row_sum_c   = 10'(i_by) + 10'(scroll_q);
    fetch_row_c = (row_sum_c >= 10'(ROWS)) ? 9'(row_sum_c - 10'(ROWS)) : 9'(row_sum_c);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scroll_q <= '0;
      off_q    <= 1'b0;
    end else begin
      scroll_q <= scroll_d;
      off_q    <= i_offscreen;
    end
  end
`else
  assign fetch_row_c = i_by;
`endif

  // Port arbitration and clear-sweep FSM.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
    wdata_d   = wdata_q;
    err_d     = 1'b0;
    char_d    = char_q;

    if (fetch_p2_q) begin
      char_d = i_mem_rdata;
    end

    if (fetch_slot_c) begin
      addr_d = cell_addr(fetch_row_c, i_bx);
    end else if (state_q == CLEAR) begin
      addr_d  = clr_cnt_q;
      we_d    = 1'b1;
      wdata_d = CLEAR_CHAR;
      if (clr_cnt_q == 15'(CELLS - 1)) begin
        state_d = IDLE;
      end else begin
        clr_cnt_d = clr_cnt_q + 15'd1;
      end
    end else if (wr_xfer_c) begin
      err_d = wr_oor_c;
      if (!wr_oor_c) begin
        addr_d  = cell_addr({1'b0, i_wr_row}, {1'b0, i_wr_col});
        wdata_d = i_wr_data;
        we_d    = 1'b1;
      end
    end

    // A writer transfer in the same cycle still completes; the sweep follows it.
    if ((state_q == IDLE) && i_clear_req) begin
      state_d   = CLEAR;
      clr_cnt_d = '0;
    end

    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      char_q     <= '0;
      fetch_p1_q <= 1'b0;
      fetch_p2_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      char_q     <= char_d;
      fetch_p1_q <= fetch_slot_c;
      fetch_p2_q <= fetch_p1_q;
    end
  end

  assign o_char       = char_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_we     = we_q;
  assign o_mem_wdata  = wdata_q;
  assign o_wr_err     = err_q;
  assign o_clear_busy = busy_q;

endmodule

// File: tb/tb_text_buffer_arbiter.sv
// Directed self-checking bench for text_buffer_arbiter with a 1-cycle-latency RAM model.
module tb_text_buffer_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  bx, by;
  logic [2:0]  px_lo;
  logic        offscreen;
  logic [15:0] char_o;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_col, wr_row;
  logic [15:0] wr_data;
  logic        wr_err;
  logic        clear_req, clear_busy;
`ifdef TEXT_BUFFER_ARBITER_SCROLL_EN
  logic [7:0]  scroll_row;
`endif

  logic [15:0] mem [0:32767];
  logic        pl_en = 1'b0;
  logic [14:0] pl_addr;
  logic [15:0] pl_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  text_buffer_arbiter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_bx         (bx),
    .i_by         (by),
    .i_px_lo      (px_lo),
    .i_offscreen  (offscreen),
    .o_char       (char_o),
    .o_mem_addr   (mem_addr),
    .o_mem_we     (mem_we),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata),
    .i_wr_valid   (wr_valid),
    .o_wr_ready   (wr_ready),
    .i_wr_col     (wr_col),
    .i_wr_row     (wr_row),
    .i_wr_data    (wr_data),
    .o_wr_err     (wr_err),
`ifdef TEXT_BUFFER_ARBITER_SCROLL_EN
    .i_scroll_row (scroll_row),
`endif
    .i_clear_req  (clear_req),
    .o_clear_busy (clear_busy)
  );

  // Synchronous single-port RAM; bench preloads go through the same process.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bx = 9'd0; by = 9'd0; px_lo = 3'd1; offscreen = 1'b0;
    wr_valid = 1'b0; wr_col = 8'd0; wr_row = 8'd0; wr_data = 16'h0000;
    clear_req = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
`ifdef TEXT_BUFFER_ARBITER_SCROLL_EN
    scroll_row = 8'd0;
`endif
    rst = 1'b1;
    repeat (3) cyc();
    checks++;
    if ({char_o, mem_addr, mem_we, mem_wdata, wr_err, clear_busy} !== 50'd0) begin
      failures++;
      $display("FAIL reset_outputs: char=%h addr=%0d we=%b wdata=%h err=%b busy=%b, required all 0",
               char_o, mem_addr, mem_we, mem_wdata, wr_err, clear_busy);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_write();
    wr_valid = 1'b1; wr_col = 8'd5; wr_row = 8'd2; wr_data = 16'h41F0;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin failures++; $display("FAIL write_ready: got %b want 1", wr_ready); end
    cyc();
    wr_valid = 1'b0;
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 15'd485, 16'h41F0}) begin
      failures++;
      $display("FAIL write_issue: we=%b addr=%0d wdata=%h, want we=1 addr=485 wdata=41f0", mem_we, mem_addr, mem_wdata);
    end
    cyc();
    checks++;
    if (mem_we !== 1'b0) begin failures++; $display("FAIL write_single: we=%b want 0", mem_we); end
  endtask

  task automatic test_write_stall();
    px_lo = 3'd0; bx = 9'd10; by = 9'd0;
    wr_valid = 1'b1; wr_col = 8'd7; wr_row = 8'd1; wr_data = 16'h1234;
    #1;
    checks++;
    if (wr_ready !== 1'b0) begin failures++; $display("FAIL stall_ready_fetch: got %b want 0", wr_ready); end
    cyc();
    px_lo = 3'd1;
    #1;
    checks++;
    if ({wr_ready, mem_we, mem_addr} !== {1'b1, 1'b0, 15'd10}) begin
      failures++;
      $display("FAIL stall_after_fetch: ready=%b we=%b addr=%0d, want ready=1 we=0 addr=10", wr_ready, mem_we, mem_addr);
    end
    cyc();
    wr_valid = 1'b0;
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 15'd247, 16'h1234}) begin
      failures++;
      $display("FAIL stall_write: we=%b addr=%0d wdata=%h, want we=1 addr=247 wdata=1234", mem_we, mem_addr, mem_wdata);
    end
    cyc();
    checks++;
    if (mem_we !== 1'b0) begin failures++; $display("FAIL stall_no_dup: we=%b want 0", mem_we); end
  endtask

  task automatic test_fetch();
    pl_en = 1'b1; pl_addr = 15'd243; pl_data = 16'h5A12;
    cyc();
    pl_en = 1'b0;
    px_lo = 3'd0; bx = 9'd3; by = 9'd1;
    cyc();
    px_lo = 3'd1;
    checks++;
    if ({mem_addr, mem_we} !== {15'd243, 1'b0}) begin
      failures++;
      $display("FAIL fetch_addr: addr=%0d we=%b, want addr=243 we=0", mem_addr, mem_we);
    end
    cyc();
    px_lo = 3'd2;
    cyc();
    checks++;
    if (char_o !== 16'h5A12) begin failures++; $display("FAIL fetch_char: got %h want 5a12", char_o); end
    // Hold through non-slot pixels, an out-of-range column and a blanking cycle.
    for (int i = 0; i < 8; i++) begin
      px_lo = 3'(3 + i); bx = 9'd3; offscreen = 1'b0;
      if (i == 2) begin px_lo = 3'd0; bx = 9'd240; end
      if (i == 5) begin px_lo = 3'd0; bx = 9'd5; offscreen = 1'b1; end
      cyc();
      checks++;
      if ({char_o, mem_addr} !== {16'h5A12, 15'd243}) begin
        failures++;
        $display("FAIL fetch_hold[%0d]: char=%h addr=%0d, want char=5a12 addr=243", i, char_o, mem_addr);
      end
    end
    idle_inputs();
    cyc();
  endtask

  task automatic test_wr_err();
    for (int k = 0; k < 2; k++) begin
      wr_valid = 1'b1; wr_data = 16'hFFFF;
      wr_col = (k == 0) ? 8'd240 : 8'd0;
      wr_row = (k == 0) ? 8'd0 : 8'd135;
      #1;
      checks++;
      if (wr_ready !== 1'b1) begin failures++; $display("FAIL err_ready[%0d]: got %b want 1", k, wr_ready); end
      cyc();
      wr_valid = 1'b0;
      checks++;
      if ({mem_we, wr_err} !== 2'b01) begin
        failures++;
        $display("FAIL err_pulse[%0d]: we=%b err=%b, want we=0 err=1", k, mem_we, wr_err);
      end
      cyc();
      checks++;
      if ({mem_we, wr_err} !== 2'b00) begin
        failures++;
        $display("FAIL err_width[%0d]: we=%b err=%b, want 0 0", k, mem_we, wr_err);
      end
    end
  endtask

  task automatic test_clear();
    int n_clear = 0;
    int bad_fetch_we = 0;
    int bad_ready = 0;
    int done = 0;
    int budget = 40000;
    int bad_cells = 0;
    logic prev_fetch = 1'b0;
    offscreen = 1'b1;
    clear_req = 1'b1;
    wr_valid = 1'b1; wr_col = 8'd1; wr_row = 8'd0; wr_data = 16'hABCD;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin failures++; $display("FAIL clear_wr_ready: got %b want 1", wr_ready); end
    cyc();
    clear_req = 1'b0; wr_valid = 1'b0;
    checks++;
    if ({clear_busy, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 15'd1, 16'hABCD}) begin
      failures++;
      $display("FAIL clear_writer_first: busy=%b we=%b addr=%0d wdata=%h, want 1 1 1 abcd",
               clear_busy, mem_we, mem_addr, mem_wdata);
    end
    cyc();
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 15'd0, 16'h2070}) begin
      failures++;
      $display("FAIL clear_first_sweep: we=%b addr=%0d wdata=%h, want 1 0 2070", mem_we, mem_addr, mem_wdata);
    end
    else n_clear = 1;
    for (int i = 0; (i < budget) && (done < 2); i++) begin
      cyc();
      if (prev_fetch && mem_we) bad_fetch_we++;
      if (mem_we && (mem_wdata == 16'h2070)) n_clear++;
      if (!clear_busy) done++;
      prev_fetch = ((i % 50) == 7);
      offscreen = !prev_fetch; px_lo = prev_fetch ? 3'd0 : 3'd1; bx = 9'd0; by = 9'd0;
      clear_req = (i == 100) || (i == 20000);
      #1;
      if (wr_ready && clear_busy) bad_ready++;
    end
    idle_inputs();
    cyc();
    checks++;
    if (done < 2) begin failures++; $display("FAIL clear_timeout: busy=%b still set after budget", clear_busy); end
    checks++;
    if (n_clear != 32400) begin failures++; $display("FAIL clear_count: %0d sweep writes, want 32400", n_clear); end
    checks++;
    if (bad_fetch_we != 0) begin failures++; $display("FAIL clear_we_after_fetch: %0d cycles, want 0", bad_fetch_we); end
    checks++;
    if (bad_ready != 0) begin failures++; $display("FAIL clear_ready_stall: %0d cycles ready during sweep, want 0", bad_ready); end
    for (int a = 0; a < 32400; a++) if (mem[a] !== 16'h2070) bad_cells++;
    checks++;
    if (bad_cells != 0) begin failures++; $display("FAIL clear_contents: %0d cells not 2070, want 0", bad_cells); end
  endtask

  task automatic test_reset_mid_clear();
    offscreen = 1'b1;
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    repeat (100) cyc();
    checks++;
    if (clear_busy !== 1'b1) begin failures++; $display("FAIL midclear_busy: got %b want 1", clear_busy); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({clear_busy, mem_we, mem_addr} !== {1'b0, 1'b0, 15'd0}) begin
      failures++;
      $display("FAIL midclear_async_reset: busy=%b we=%b addr=%0d, want 0 0 0", clear_busy, mem_we, mem_addr);
    end
    cyc();
    rst = 1'b0;
    idle_inputs();
    cyc();
    checks++;
    if ({clear_busy, wr_ready, mem_we} !== 3'b010) begin
      failures++;
      $display("FAIL midclear_idle: busy=%b ready=%b we=%b, want 0 1 0", clear_busy, wr_ready, mem_we);
    end
  endtask

`ifdef TEXT_BUFFER_ARBITER_SCROLL_EN
  task automatic test_scroll();
    for (int k = 0; k < 2; k++) begin
      scroll_row = (k == 0) ? 8'd130 : 8'd200;
      offscreen = 1'b1;
      cyc();
      offscreen = 1'b0; px_lo = 3'd0; bx = 9'd3; by = 9'd10;
      cyc();
      idle_inputs();
      checks++;
      if (mem_addr !== ((k == 0) ? 15'd1203 : 15'd2163)) begin
        failures++;
        $display("FAIL scroll_addr[%0d]: got %0d want %0d", k, mem_addr, (k == 0) ? 1203 : 2163);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_write_stall();
    test_fetch();
    test_wr_err();
    test_clear();
    test_reset_mid_clear();
`ifdef TEXT_BUFFER_ARBITER_SCROLL_EN
    test_scroll();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
